// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared state encoding and default widths for the run controller.
package clock_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int TOT_W_DEF = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BURST, ST_STEP} state_e;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector that needs a low sample after reset before it can fire.
module edge_detect (
  input  logic CLOCK,
  input  logic nRESET,
  input  logic IN,
  output logic RISE
);
  // armed_q means "IN was sampled low at the previous edge"; clearing it in reset
  // keeps a level held across reset release from looking like a fresh request.
  logic armed_q;
  always_ff @(posedge CLOCK or negedge nRESET)
    if (!nRESET) armed_q <= 1'b0;
    else armed_q <= ~IN;
  assign RISE = IN & armed_q;
endmodule

// File: rtl/clock_run_ctrl.sv
// clock_run_ctrl: run/step/burst clock-enable controller with halt and enabled-cycle totals.
module clock_run_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input  logic             CLOCK,
  input  logic             nRESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             BURST,
  input  logic [CNT_W-1:0] CYCLES,
  input  logic             HALT,
  input  logic             HALT_REQ,
  output logic             ENABLE,
  output logic             RUNNING,
  output logic             DONE,
  output logic [CNT_W-1:0] REMAIN,
  output logic [TOT_W-1:0] TOTAL
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [TOT_W-1:0] total_q;
  logic enable_q, done_q, done_d;
  logic run_rise, step_rise, burst_rise;
  wire halt = HALT | HALT_REQ;
  edge_detect u_run   (.CLOCK(CLOCK), .nRESET(nRESET), .IN(RUN),   .RISE(run_rise));
  edge_detect u_step  (.CLOCK(CLOCK), .nRESET(nRESET), .IN(STEP),  .RISE(step_rise));
  edge_detect u_burst (.CLOCK(CLOCK), .nRESET(nRESET), .IN(BURST), .RISE(burst_rise));
  // Requests are only looked at in IDLE, so edges seen while busy are simply lost.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE:
        if (!halt) begin
          if (step_rise) state_d = ST_STEP;
          else if (burst_rise) begin
            if (CYCLES == '0) done_d = 1'b1;
            else begin
              state_d  = ST_BURST;
              remain_d = CYCLES;
            end
          end else if (run_rise) state_d = ST_RUN;
        end
      ST_STEP: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_RUN:
        if (halt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      ST_BURST:
        if (halt) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          done_d   = 1'b1;
        end else begin
          remain_d = remain_q - CNT_W'(1);
          state_d  = (remain_q == CNT_W'(1)) ? ST_IDLE : ST_BURST;
          done_d   = (remain_q == CNT_W'(1));
        end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or negedge nRESET)
    if (!nRESET) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      total_q  <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      total_q  <= total_q + TOT_W'(enable_q);
      enable_q <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  assign ENABLE  = enable_q;
  assign RUNNING = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign REMAIN  = remain_q;
  assign TOTAL   = total_q;
endmodule

// File: tb/tb_clock_run_ctrl.sv
// tb_clock_run_ctrl: directed scenario tests for clock_run_ctrl.
module tb_clock_run_ctrl;
  logic CLOCK = 1'b0, nRESET = 1'b0;
  logic RUN = 1'b0, STEP = 1'b0, BURST = 1'b0, HALT = 1'b0, HALT_REQ = 1'b0;
  logic [15:0] CYCLES = '0;
  logic ENABLE, RUNNING, DONE;
  logic [15:0] REMAIN;
  logic [31:0] TOTAL;
  logic w_enable, w_running, w_done;
  logic [15:0] w_remain;
  logic [3:0] w_total;
  int nchk = 0, nbad = 0;
  logic [31:0] exp_total = '0;

  always #5 CLOCK = ~CLOCK;

  clock_run_ctrl dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .RUN(RUN), .STEP(STEP), .BURST(BURST),
    .CYCLES(CYCLES), .HALT(HALT), .HALT_REQ(HALT_REQ), .ENABLE(ENABLE),
    .RUNNING(RUNNING), .DONE(DONE), .REMAIN(REMAIN), .TOTAL(TOTAL)
  );
  clock_run_ctrl #(.TOT_W(4)) dut_w (
    .CLOCK(CLOCK), .nRESET(nRESET), .RUN(RUN), .STEP(STEP), .BURST(BURST),
    .CYCLES(CYCLES), .HALT(HALT), .HALT_REQ(HALT_REQ), .ENABLE(w_enable),
    .RUNNING(w_running), .DONE(w_done), .REMAIN(w_remain), .TOTAL(w_total)
  );

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b000) begin nbad++; $display("FAIL reset_flags got=%b want=000", {ENABLE, RUNNING, DONE}); end
    nchk++; if (REMAIN !== 16'd0 || TOTAL !== 32'd0) begin nbad++; $display("FAIL reset_counts remain=%0d total=%0d want 0", REMAIN, TOTAL); end
    tick();
    nRESET = 1'b1;
    tick();
    nchk++; if (ENABLE !== 1'b0) begin nbad++; $display("FAIL idle_after_reset enable=%b want=0", ENABLE); end
  endtask

  task automatic test_step();
    STEP = 1'b1;
    nchk++; if (ENABLE !== 1'b0) begin nbad++; $display("FAIL step_pre enable=%b want=0", ENABLE); end
    tick();
    STEP = 1'b0;
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b110) begin nbad++; $display("FAIL step_on got=%b want=110", {ENABLE, RUNNING, DONE}); end
    tick();
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b001) begin nbad++; $display("FAIL step_done got=%b want=001", {ENABLE, RUNNING, DONE}); end
    tick();
    exp_total = 32'd1;
    nchk++; if (DONE !== 1'b0 || TOTAL !== exp_total) begin nbad++; $display("FAIL step_total done=%b total=%0d want 0/%0d", DONE, TOTAL, exp_total); end
  endtask

  task automatic test_burst4();
    CYCLES = 16'd4;
    BURST = 1'b1;
    tick();
    BURST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nchk++; if (ENABLE !== 1'b1 || DONE !== 1'b0 || REMAIN !== 16'(4 - i)) begin nbad++; $display("FAIL burst4_cyc%0d en=%b done=%b remain=%0d want 1/0/%0d", i, ENABLE, DONE, REMAIN, 4 - i); end
      tick();
    end
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b001 || REMAIN !== 16'd0) begin nbad++; $display("FAIL burst4_end got=%b remain=%0d want=001/0", {ENABLE, RUNNING, DONE}, REMAIN); end
    tick();
    exp_total += 4;
    nchk++; if (DONE !== 1'b0 || ENABLE !== 1'b0 || TOTAL !== exp_total) begin nbad++; $display("FAIL burst4_total done=%b en=%b total=%0d want 0/0/%0d", DONE, ENABLE, TOTAL, exp_total); end
  endtask

  task automatic test_burst0();
    CYCLES = 16'd0;
    BURST = 1'b1;
    tick();
    BURST = 1'b0;
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b001) begin nbad++; $display("FAIL burst0_done got=%b want=001", {ENABLE, RUNNING, DONE}); end
    tick();
    nchk++; if (DONE !== 1'b0 || ENABLE !== 1'b0 || TOTAL !== exp_total) begin nbad++; $display("FAIL burst0_after done=%b en=%b total=%0d want 0/0/%0d", DONE, ENABLE, TOTAL, exp_total); end
  endtask

  task automatic test_run_halt();
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nchk++; if (ENABLE !== 1'b1 || RUNNING !== 1'b1) begin nbad++; $display("FAIL run_cyc%0d en=%b running=%b want 1/1", i, ENABLE, RUNNING); end
      if (i == 2) STEP = 1'b1;
      if (i == 3) STEP = 1'b0;
      if (i == 9) HALT = 1'b1;
      tick();
    end
    HALT = 1'b0;
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b001) begin nbad++; $display("FAIL run_halt got=%b want=001", {ENABLE, RUNNING, DONE}); end
    tick();
    exp_total += 10;
    nchk++; if (ENABLE !== 1'b0 || DONE !== 1'b0 || TOTAL !== exp_total) begin nbad++; $display("FAIL run_total en=%b done=%b total=%0d want 0/0/%0d", ENABLE, DONE, TOTAL, exp_total); end
  endtask

  task automatic test_priority();
    HALT_REQ = 1'b1;
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    HALT_REQ = 1'b0;
    nchk++; if (ENABLE !== 1'b0 || DONE !== 1'b0) begin nbad++; $display("FAIL halt_blocks en=%b done=%b want 0/0", ENABLE, DONE); end
    tick();
    CYCLES = 16'd7;
    STEP = 1'b1;
    BURST = 1'b1;
    tick();
    STEP = 1'b0;
    BURST = 1'b0;
    nchk++; if (ENABLE !== 1'b1 || REMAIN !== 16'd0) begin nbad++; $display("FAIL prio_step en=%b remain=%0d want 1/0", ENABLE, REMAIN); end
    tick();
    nchk++; if (ENABLE !== 1'b0 || DONE !== 1'b1) begin nbad++; $display("FAIL prio_done en=%b done=%b want 0/1", ENABLE, DONE); end
    tick();
    exp_total += 1;
    nchk++; if (TOTAL !== exp_total) begin nbad++; $display("FAIL prio_total total=%0d want %0d", TOTAL, exp_total); end
  endtask

  task automatic test_async_reset();
    CYCLES = 16'd100;
    BURST = 1'b1;
    tick();
    repeat (5) tick();
    nchk++; if (ENABLE !== 1'b1 || REMAIN !== 16'd95) begin nbad++; $display("FAIL midburst en=%b remain=%0d want 1/95", ENABLE, REMAIN); end
    #2 nRESET = 1'b0;
    #1;
    nchk++; if ({ENABLE, RUNNING, DONE} !== 3'b000 || REMAIN !== 16'd0 || TOTAL !== 32'd0) begin nbad++; $display("FAIL async_rst flags=%b remain=%0d total=%0d want 000/0/0", {ENABLE, RUNNING, DONE}, REMAIN, TOTAL); end
    tick();
    nRESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++; if (ENABLE !== 1'b0 || DONE !== 1'b0) begin nbad++; $display("FAIL held_burst%0d en=%b done=%b want 0/0", i, ENABLE, DONE); end
    end
    BURST = 1'b0;
    tick();
    BURST = 1'b1;
    tick();
    BURST = 1'b0;
    nchk++; if (ENABLE !== 1'b1 || REMAIN !== 16'd100) begin nbad++; $display("FAIL rearm_burst en=%b remain=%0d want 1/100", ENABLE, REMAIN); end
  endtask

  task automatic test_wrap();
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      tick();
      tick();
    end
    nchk++; if (w_total !== 4'd1) begin nbad++; $display("FAIL wrap4 total=%0d want 1", w_total); end
    nchk++; if (TOTAL !== 32'd17) begin nbad++; $display("FAIL wrap32 total=%0d want 17", TOTAL); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_burst4();
    test_burst0();
    test_run_halt();
    test_priority();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
